// File: rtl/nf10_pcap_replay_pkg.sv
// Shared types and defaults for the QDR packet-replay controller.
// Holds the FSM state encoding and the default loop-counter width.
package nf10_pcap_replay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2,
        ST_DONE   = 2'd3
    } replay_state_e;

    localparam int CNT_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/replay_addr_gen.sv
// Read-address and pass counter for replay: walks rd_ptr over the loaded
// region, wraps at wr_cnt-1 and counts completed passes.
module replay_addr_gen
    import nf10_pcap_replay_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_ADDR_LOW   = 0,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      clear_i,
    input  logic                      issue_i,
    input  logic [MEM_ADDR_WIDTH-1:0] wr_cnt_i,
    input  logic [CNT_WIDTH-1:0]      replay_count_i,
    output logic                      finish_o,
    output logic [CNT_WIDTH-1:0]      loop_cnt_o,
    output logic                      mem_r_n_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd_o
);

    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_BASE = MEM_ADDR_WIDTH'(MEM_ADDR_LOW);

    logic [MEM_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]      loop_cnt_q, loop_cnt_d;
    logic                      mem_r_n_q, mem_r_n_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd_q, mem_ad_rd_d;
    logic                      wrap;

    assign wrap = (rd_ptr_q == wr_cnt_i - MEM_ADDR_WIDTH'(1));

    // The issue that completes the last requested pass ends the replay.
    assign finish_o = issue_i && wrap && (replay_count_i != '0) &&
                      (loop_cnt_q + CNT_WIDTH'(1) == replay_count_i);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        loop_cnt_d  = loop_cnt_q;
        mem_r_n_d   = 1'b1;
        mem_ad_rd_d = mem_ad_rd_q;
        if (clear_i) begin
            rd_ptr_d   = '0;
            loop_cnt_d = '0;
        end else if (issue_i) begin
            mem_r_n_d   = 1'b0;
            mem_ad_rd_d = ADDR_BASE + rd_ptr_q;
            if (wrap) begin
                rd_ptr_d   = '0;
                loop_cnt_d = loop_cnt_q + CNT_WIDTH'(1);
            end else begin
                rd_ptr_d = rd_ptr_q + MEM_ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_q    <= '0;
            loop_cnt_q  <= '0;
            mem_r_n_q   <= 1'b1;
            mem_ad_rd_q <= ADDR_BASE;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            loop_cnt_q  <= loop_cnt_d;
            mem_r_n_q   <= mem_r_n_d;
            mem_ad_rd_q <= mem_ad_rd_d;
        end
    end

    assign loop_cnt_o  = loop_cnt_q;
    assign mem_r_n_o   = mem_r_n_q;
    assign mem_ad_rd_o = mem_ad_rd_q;

endmodule

// File: rtl/qdr_replay_ctrl.sv
// QDR replay controller: loads a packet region through the writer, then
// replays it as read bursts for a programmed number of passes.
module qdr_replay_ctrl
    import nf10_pcap_replay_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 19,
    parameter int MEM_ADDR_LOW   = 0,
    parameter int CNT_WIDTH      = CNT_WIDTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sw_rst,
    input  logic                      cal_done,
    input  logic                      start_replay,
    input  logic                      stop_replay,
    input  logic [CNT_WIDTH-1:0]      replay_count,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr_high,
    output logic                      writer_en,
    input  logic                      mem_wr_cmd_n,
    input  logic                      mem_rd_full,
    input  logic                      out_prog_full,
    output logic                      mem_r_n,
    output logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd,
    output logic [MEM_ADDR_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0]      loop_cnt,
    output logic                      busy,
    output logic                      replay_done
);

    replay_state_e             state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic                      writer_en_q, busy_q, done_q;
    logic                      srst, issue, clear, finish;

    assign srst = !rst_n || sw_rst;

    // A stop pulse suppresses the issue in its own cycle.
    assign issue = (state_q == ST_REPLAY) && cal_done && !mem_rd_full &&
                   !out_prog_full && !stop_replay;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        clear    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cal_done) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (!mem_wr_cmd_n && (wr_cnt_q < mem_addr_high))
                    wr_cnt_d = wr_cnt_q + MEM_ADDR_WIDTH'(1);
                if (start_replay && !stop_replay && (wr_cnt_q != '0)) begin
                    state_d = ST_REPLAY;
                    clear   = 1'b1;
                end
            end
            ST_REPLAY: begin
                if (stop_replay || finish) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_replay && !stop_replay) begin
                    state_d = ST_REPLAY;
                    clear   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            wr_cnt_q    <= '0;
            writer_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            writer_en_q <= (state_d == ST_LOAD);
            busy_q      <= (state_d == ST_REPLAY);
            done_q      <= (state_d == ST_DONE);
        end
    end

    replay_addr_gen #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .MEM_ADDR_LOW   (MEM_ADDR_LOW),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_addr_gen (
        .clk            (clk),
        .srst           (srst),
        .clear_i        (clear),
        .issue_i        (issue),
        .wr_cnt_i       (wr_cnt_q),
        .replay_count_i (replay_count),
        .finish_o       (finish),
        .loop_cnt_o     (loop_cnt),
        .mem_r_n_o      (mem_r_n),
        .mem_ad_rd_o    (mem_ad_rd)
    );

    assign writer_en   = writer_en_q;
    assign wr_cnt      = wr_cnt_q;
    assign busy        = busy_q;
    assign replay_done = done_q;

endmodule

// File: tb/tb_qdr_replay_ctrl.sv
// Scoreboard bench for qdr_replay_ctrl: expected read addresses are queued
// as each replay is launched and checked as read strobes appear.
module tb_qdr_replay_ctrl;

    localparam int AW = 19;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n, sw_rst, cal_done, start_replay, stop_replay;
    logic [CW-1:0] replay_count;
    logic [AW-1:0] mem_addr_high;
    logic          writer_en, mem_wr_cmd_n, mem_rd_full, out_prog_full;
    logic          mem_r_n, busy, replay_done;
    logic [AW-1:0] mem_ad_rd, wr_cnt;
    logic [CW-1:0] loop_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int rd_seen = 0;
    int cyc = 0;
    int rd_cyc_last = 0;
    logic blk_q = 1'b1;
    logic [AW-1:0] exp_q[$];

    qdr_replay_ctrl #(.MEM_ADDR_WIDTH(AW), .MEM_ADDR_LOW(0), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw_rst        (sw_rst),
        .cal_done      (cal_done),
        .start_replay  (start_replay),
        .stop_replay   (stop_replay),
        .replay_count  (replay_count),
        .mem_addr_high (mem_addr_high),
        .writer_en     (writer_en),
        .mem_wr_cmd_n  (mem_wr_cmd_n),
        .mem_rd_full   (mem_rd_full),
        .out_prog_full (out_prog_full),
        .mem_r_n       (mem_r_n),
        .mem_ad_rd     (mem_ad_rd),
        .wr_cnt        (wr_cnt),
        .loop_cnt      (loop_cnt),
        .busy          (busy),
        .replay_done   (replay_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Remember whether the edge that could have issued was blocked or stopped.
    always @(posedge clk) begin
        blk_q <= mem_rd_full || out_prog_full || !cal_done || stop_replay;
        cyc   <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!mem_r_n) begin
            rd_seen++;
            rd_cyc_last = cyc;
            chk("no_read_after_block", {63'd0, blk_q}, 64'd0);
            if (exp_q.size() == 0) chk("unexpected_read", 64'd1, 64'd0);
            else chk("rd_addr", {45'd0, mem_ad_rd}, {45'd0, exp_q.pop_front()});
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic reload();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        tick();
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            mem_wr_cmd_n = 1'b0;
            tick();
        end
        mem_wr_cmd_n = 1'b1;
        tick();
    endtask

    task automatic start_pulse();
        start_replay = 1'b1;
        tick();
        start_replay = 1'b0;
    endtask

    task automatic push_seq(input int region, input int total);
        for (int i = 0; i < total; i++) exp_q.push_back(AW'(i % region));
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!replay_done && k < 300) begin
            tick();
            k++;
        end
        chk(tag, {63'd0, replay_done}, 64'd1);
    endtask

    task automatic wait_reads(input string tag, input int base, input int n);
        int k = 0;
        while ((rd_seen - base) < n && k < 300) begin
            tick();
            k++;
        end
        chk(tag, (rd_seen - base) >= n, 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_writer_en"}, {63'd0, writer_en}, 64'd0);
        chk({tag, "_mem_r_n"}, {63'd0, mem_r_n}, 64'd1);
        chk({tag, "_mem_ad_rd"}, {45'd0, mem_ad_rd}, 64'd0);
        chk({tag, "_wr_cnt"}, {45'd0, wr_cnt}, 64'd0);
        chk({tag, "_loop_cnt"}, {32'd0, loop_cnt}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_done"}, {63'd0, replay_done}, 64'd0);
    endtask

    initial begin
        int base, c0;
        rst_n = 1'b0; sw_rst = 1'b0; cal_done = 1'b0;
        start_replay = 1'b0; stop_replay = 1'b0;
        replay_count = '0; mem_addr_high = AW'(16);
        mem_wr_cmd_n = 1'b1; mem_rd_full = 1'b0; out_prog_full = 1'b0;
        tick(); tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_writer", {63'd0, writer_en}, 64'd0);
        cal_done = 1'b1;
        tick();
        chk("load_writer_en", {63'd0, writer_en}, 64'd1);

        // Load eight bursts, single pass.
        load_n(8);
        chk("t1_wr_cnt", {45'd0, wr_cnt}, 64'd8);
        replay_count = 1;
        base = rd_seen;
        push_seq(8, 8);
        start_pulse();
        chk("t1_busy", {63'd0, busy}, 64'd1);
        chk("t1_writer_off", {63'd0, writer_en}, 64'd0);
        wait_reads("t1_first_timeout", base, 1);
        c0 = rd_cyc_last;
        wait_done("t1_done_timeout");
        tick(); tick();
        chk("t1_reads", rd_seen - base, 64'd8);
        chk("t1_consecutive", rd_cyc_last - c0, 64'd7);
        chk("t1_loop_cnt", {32'd0, loop_cnt}, 64'd1);
        chk("t1_queue_empty", exp_q.size(), 64'd0);
        load_n(2);
        chk("t1_wr_hold_done", {45'd0, wr_cnt}, 64'd8);

        // Three-burst region, four passes.
        reload();
        load_n(3);
        replay_count = 4;
        base = rd_seen;
        push_seq(3, 12);
        start_pulse();
        wait_done("t2_done_timeout");
        tick(); tick();
        chk("t2_reads", rd_seen - base, 64'd12);
        chk("t2_loop_cnt", {32'd0, loop_cnt}, 64'd4);

        // Random backpressure and calibration dropouts.
        reload();
        load_n(5);
        replay_count = 3;
        base = rd_seen;
        push_seq(5, 15);
        start_pulse();
        for (int k = 0; k < 600 && !replay_done; k++) begin
            mem_rd_full   = ($urandom_range(0, 2) == 0);
            out_prog_full = ($urandom_range(0, 2) == 0);
            cal_done      = ($urandom_range(0, 7) != 0);
            tick();
        end
        mem_rd_full = 1'b0; out_prog_full = 1'b0; cal_done = 1'b1;
        chk("t3_done", {63'd0, replay_done}, 64'd1);
        tick(); tick();
        chk("t3_reads", rd_seen - base, 64'd15);
        chk("t3_loop_cnt", {32'd0, loop_cnt}, 64'd3);

        // Write counter saturates at the region size.
        reload();
        mem_addr_high = AW'(4);
        load_n(6);
        chk("t4_wr_sat", {45'd0, wr_cnt}, 64'd4);
        replay_count = 1;
        base = rd_seen;
        push_seq(4, 4);
        start_pulse();
        wait_done("t4_done_timeout");
        tick(); tick();
        chk("t4_reads", rd_seen - base, 64'd4);
        mem_addr_high = AW'(16);

        // Abort an infinite replay with start and stop together.
        reload();
        load_n(3);
        replay_count = 0;
        base = rd_seen;
        push_seq(3, 5);
        start_pulse();
        wait_reads("t5_reads_timeout", base, 5);
        start_replay = 1'b1; stop_replay = 1'b1;
        tick();
        start_replay = 1'b0; stop_replay = 1'b0;
        chk("t5_done", {63'd0, replay_done}, 64'd1);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_loop_cnt", {32'd0, loop_cnt}, 64'd1);
        repeat (5) tick();
        chk("t5_no_sixth", rd_seen - base, 64'd5);
        base = rd_seen;
        exp_q.push_back(AW'(0));
        start_pulse();
        chk("t5_restart_busy", {63'd0, busy}, 64'd1);
        chk("t5_restart_loop", {32'd0, loop_cnt}, 64'd0);
        wait_reads("t5_restart_timeout", base, 1);
        stop_replay = 1'b1;
        tick();
        stop_replay = 1'b0;
        chk("t5_stop_done", {63'd0, replay_done}, 64'd1);
        tick(); tick();
        chk("t5_restart_reads", rd_seen - base, 64'd1);

        // Software reset in the middle of a replay.
        reload();
        start_pulse();
        chk("t6_start_ignored", {63'd0, busy}, 64'd0);
        load_n(3);
        base = rd_seen;
        push_seq(3, 30);
        start_pulse();
        wait_reads("t6_sw_timeout", base, 4);
        sw_rst = 1'b1;
        tick();
        chk_reset_vals("t6_sw");
        exp_q.delete();
        sw_rst = 1'b0;
        tick();
        chk("t6_sw_reload", {63'd0, writer_en}, 64'd1);

        // Hard reset in the middle of a replay.
        load_n(3);
        base = rd_seen;
        push_seq(3, 30);
        start_pulse();
        wait_reads("t6_rst_timeout", base, 2);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("t6_rst");
        exp_q.delete();
        rst_n = 1'b1; cal_done = 1'b0;
        tick();
        chk("t6_idle_wait", {63'd0, writer_en}, 64'd0);
        cal_done = 1'b1;
        tick();
        chk("t6_rst_reload", {63'd0, writer_en}, 64'd1);
        tick(); tick();
        chk("t6_no_reads", {63'd0, mem_r_n}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/qdr_replay_ctrl.md
QDR_REPLAY_CTRL -- requirements
Module: qdr_replay_ctrl

Interface
REQ-001 SHALL have parameters (name, default, meaning): MEM_ADDR_WIDTH, 19, QDR burst-address width; MEM_ADDR_LOW, 0, base burst address of the replay region; CNT_WIDTH, 32, loop-counter width.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, reset; synchronous, active-low.
- sw_rst, in, 1, software reset; synchronous, active-high.
- cal_done, in, 1, QDR calibration complete.
- start_replay, in, 1, single-cycle start pulse.
- stop_replay, in, 1, single-cycle abort pulse.
- replay_count, in, CNT_WIDTH, number of passes; 0 means infinite.
- mem_addr_high, in, MEM_ADDR_WIDTH, region size in bursts.
- writer_en, out, 1, gates the writer's cal_done input.
- mem_wr_cmd_n, in, 1, writer write strobe; low means one burst committed.
- mem_rd_full, in, 1, QDR read command queue full.
- out_prog_full, in, 1, downstream replay FIFO programmable-full.
- mem_r_n, out, 1, read command strobe, active-low.
- mem_ad_rd, out, MEM_ADDR_WIDTH, read burst address.
- wr_cnt, out, MEM_ADDR_WIDTH, bursts loaded.
- loop_cnt, out, CNT_WIDTH, completed passes.
- busy, out, 1, state is REPLAY.
- replay_done, out, 1, state is DONE.

Function
REQ-003 SHALL implement the states IDLE, LOAD, REPLAY and DONE, held in a registered state register.
REQ-004 IDLE: SHALL move to LOAD on the first cycle in which cal_done=1.
REQ-005 LOAD: SHALL drive writer_en=1. Every cycle with mem_wr_cmd_n=0 SHALL increment wr_cnt. wr_cnt SHALL saturate at mem_addr_high.
REQ-006 LOAD: start_replay with wr_cnt!=0 SHALL move to REPLAY. rd_ptr and loop_cnt SHALL be cleared. start_replay with wr_cnt==0 SHALL be ignored.
REQ-007 writer_en SHALL be 0 in every state other than LOAD. Write strobes outside LOAD SHALL NOT change wr_cnt.
REQ-008 REPLAY: a read SHALL issue in a cycle only when cal_done=1, mem_rd_full=0 and out_prog_full=0.
- When a read issues, the next cycle SHALL have mem_r_n=0 and mem_ad_rd=MEM_ADDR_LOW+rd_ptr, both registered, for one cycle of latency.
- Otherwise mem_r_n SHALL be 1 and mem_ad_rd SHALL hold its value.
REQ-009 On each issue, rd_ptr SHALL increment. When rd_ptr==wr_cnt-1 at issue, rd_ptr SHALL wrap to 0 and loop_cnt SHALL increment.
REQ-010 When replay_count!=0 and the wrapping issue makes loop_cnt equal replay_count, the FSM SHALL move to DONE; no further reads SHALL issue. replay_count=0 SHALL loop indefinitely. loop_cnt SHALL wrap modulo 2^CNT_WIDTH.
REQ-011 stop_replay in REPLAY SHALL move to DONE next cycle; no issue SHALL occur in the stop cycle. When start_replay and stop_replay are asserted in the same cycle, stop SHALL win.
REQ-012 cal_done deasserting in REPLAY SHALL suspend issue only. State and pointers SHALL be retained.
REQ-013 DONE: start_replay SHALL re-enter REPLAY with rd_ptr=0 and loop_cnt=0. wr_cnt and the memory contents SHALL be retained. Reloading requires sw_rst.
REQ-014 busy and replay_done SHALL be registered decodes of the state.
REQ-015 Address arithmetic SHALL be MEM_ADDR_WIDTH-bit unsigned. rd_ptr SHALL never reach wr_cnt.

Reset
REQ-016 rst_n=0 or sw_rst=1 at a clock edge SHALL take priority over all other inputs, including mid-replay.
REQ-017 On reset: state=IDLE, writer_en=0, mem_r_n=1, mem_ad_rd=MEM_ADDR_LOW, wr_cnt=0, rd_ptr=0, loop_cnt=0, busy=0, replay_done=0.

Structure
REQ-018 The state encoding and a CNT_WIDTH default constant SHALL live in the shared package nf10_pcap_replay_pkg.
REQ-019 The read-address/loop generator (rd_ptr, wrap, loop_cnt) SHALL be the sub-module replay_addr_gen. The FSM and the write counter SHALL stay in qdr_replay_ctrl.

Verification
REQ-020 Load and single pass:
- Stimulus: cal_done=1, 8 write strobes, replay_count=1, start pulse, no backpressure.
- Required response: exactly 8 reads at addresses 0..7 on consecutive cycles, then replay_done=1 and loop_cnt=1.
REQ-021 Multi-pass wrap:
- Stimulus: wr_cnt=3, replay_count=4.
- Required response: address sequence 0,1,2 repeated 4 times (12 reads), then DONE.
REQ-022 Backpressure:
- Stimulus: toggle out_prog_full and mem_rd_full randomly.
- Required response: no mem_r_n=0 in any cycle following a blocked cycle; address sequence gap-free; read count unchanged.
REQ-023 Saturation:
- Stimulus: mem_addr_high=4, 6 write strobes.
- Required response: wr_cnt=4; replay covers addresses 0..3.
REQ-024 Abort:
- Stimulus: replay_count=0; stop_replay after 5 reads, asserted together with start_replay.
- Required response: DONE and no sixth read. A later start restarts at address 0 with loop_cnt=0.
REQ-025 Reset mid-operation:
- Stimulus: sw_rst mid-REPLAY, and separately rst_n=0 mid-REPLAY.
- Required response: all outputs take their REQ-017 values on the next cycle; FSM returns to IDLE, then LOAD once cal_done=1.
